// File: rtl/bcd_time_display_scan.sv
// Reader of the 12-hour BCD time bus: snapshots once per frame and scans a 6-digit
// common-anode display (HH MM SS) with PM lamp, blinking colon and sticky bad-BCD flag.
module bcd_time_display_scan #(
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] hh,
   input  logic [7:0] mm,
   input  logic [7:0] ss,
   input  logic       pm,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       pm_led,
   output logic       bcd_err
);

   localparam int            CW      = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    snap_hh, snap_mm, snap_ss;
   logic          snap_pm;
   logic          slot_end, frame_end, blank, load_err;
   logic [3:0]    nib;
   logic [5:0]    an_nxt;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;

   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0:    enc = 7'h40;
         4'd1:    enc = 7'h79;
         4'd2:    enc = 7'h24;
         4'd3:    enc = 7'h30;
         4'd4:    enc = 7'h19;
         4'd5:    enc = 7'h12;
         4'd6:    enc = 7'h02;
         4'd7:    enc = 7'h78;
         4'd8:    enc = 7'h00;
         4'd9:    enc = 7'h10;
         default: enc = 7'h3F;
      endcase
   endfunction

   function automatic logic over9(input logic [3:0] d);
      over9 = (d > 4'd9);
   endfunction

   assign slot_end  = (cnt == CNT_MAX);
   assign frame_end = slot_end && (idx == 3'd5);

   generate
      if (BLANK_CYC == 0) begin : g_noblank
         assign blank = 1'b0;
      end else begin : g_blank
         assign blank = (32'(cnt) < $unsigned(BLANK_CYC));
      end
   endgenerate

   // Judged on the live bus, since this is exactly what gets loaded on a boundary.
   assign load_err = over9(hh[7:4]) | over9(hh[3:0]) | over9(mm[7:4]) |
                     over9(mm[3:0]) | over9(ss[7:4]) | over9(ss[3:0]) |
                     (hh == 8'h00);

   always_comb begin
      nib     = 4'd0;
      an_nxt  = 6'b111111;
      seg_nxt = 7'h7F;
      dp_nxt  = 1'b1;
      case (idx)
         3'd0:    nib = snap_hh[7:4];
         3'd1:    nib = snap_hh[3:0];
         3'd2:    nib = snap_mm[7:4];
         3'd3:    nib = snap_mm[3:0];
         3'd4:    nib = snap_ss[7:4];
         3'd5:    nib = snap_ss[3:0];
         default: nib = 4'd0;
      endcase
      if (!blank) begin
         an_nxt  = ~(6'b000001 << idx);
         seg_nxt = (idx == 3'd0 && snap_hh[7:4] == 4'd0) ? 7'h7F : enc(nib);
         dp_nxt  = ~(((idx == 3'd1) || (idx == 3'd3)) && !snap_ss[0]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         idx     <= 3'd0;
         snap_hh <= 8'h12;
         snap_mm <= 8'h00;
         snap_ss <= 8'h00;
         snap_pm <= 1'b0;
         an      <= 6'b111111;
         seg     <= 7'h7F;
         dp      <= 1'b1;
         pm_led  <= 1'b0;
         bcd_err <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end) begin
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
         end
         if (frame_end) begin
            snap_hh <= hh;
            snap_mm <= mm;
            snap_ss <= ss;
            snap_pm <= pm;
            if (load_err) begin
               bcd_err <= 1'b1;
            end
         end
         an     <= an_nxt;
         seg    <= seg_nxt;
         dp     <= dp_nxt;
         pm_led <= snap_pm;
      end
   end

endmodule

// File: tb/tb_bcd_time_display_scan.sv
// Scoreboard bench: per-cycle expected display words are queued per frame and
// compared against the DUT on the falling edge.
module tb_bcd_time_display_scan;

   typedef struct packed {
      logic [5:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       pm;
   } rec_t;

   logic       clk, reset, pm;
   logic [7:0] hh, mm, ss;
   logic [5:0] an_a, an_b;
   logic [6:0] seg_a, seg_b;
   logic       dp_a, dp_b, pmled_a, pmled_b, err_a, err_b;

   int   checks = 0;
   int   errors = 0;
   rec_t q[$];

   bcd_time_display_scan #(.SCAN_DIV(8), .BLANK_CYC(2)) dut_a (
      .clk(clk), .reset(reset), .hh(hh), .mm(mm), .ss(ss), .pm(pm),
      .an(an_a), .seg(seg_a), .dp(dp_a), .pm_led(pmled_a), .bcd_err(err_a));

   bcd_time_display_scan #(.SCAN_DIV(2), .BLANK_CYC(0)) dut_b (
      .clk(clk), .reset(reset), .hh(hh), .mm(mm), .ss(ss), .pm(pm),
      .an(an_b), .seg(seg_b), .dp(dp_b), .pm_led(pmled_b), .bcd_err(err_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] digit_seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
         4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
         4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
         4'd9: return 7'h10;  default: return 7'h3F;
      endcase
   endfunction

   // Queue the expected output word for every cycle of one displayed frame.
   task automatic push_frame(input int div, input int blank,
                             input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s, input logic p);
      rec_t       r;
      logic [3:0] n;
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: n = h[7:4];  1: n = h[3:0];  2: n = m[7:4];
            3: n = m[3:0];  4: n = s[7:4];  default: n = s[3:0];
         endcase
         for (int c = 0; c < div; c++) begin
            r.pm = p;
            if (c < blank) begin
               r.an = 6'b111111; r.seg = 7'h7F; r.dp = 1'b1;
            end else begin
               r.an  = 6'b111111 ^ (6'b000001 << i);
               r.seg = (i == 0 && n == 4'd0) ? 7'h7F : digit_seg(n);
               r.dp  = !((i == 1 || i == 3) && s[0] == 1'b0);
            end
            q.push_back(r);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      hh = 8'h12; mm = 8'h00; ss = 8'h00; pm = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (an_a !== 6'b111111) begin errors++; $display("FAIL reset_an got %b want 111111", an_a); end
      checks++; if (seg_a !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", seg_a); end
      checks++; if (dp_a !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp_a); end
      checks++; if (pmled_a !== 1'b0) begin errors++; $display("FAIL reset_pm_led got %b want 0", pmled_a); end
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_bcd_err got %b want 0", err_a); end
      reset = 1'b0;
   endtask

   task automatic test_first_frame;
      rec_t e;
      push_frame(8, 2, 8'h12, 8'h00, 8'h00, 1'b0);
      for (int j = 0; j < 48; j++) begin
         @(negedge clk);
         e = q.pop_front();
         checks++;
         if ({an_a, seg_a, dp_a, pmled_a} !== e) begin
            errors++;
            $display("FAIL first_frame cyc %0d got an=%b seg=%h dp=%b pm=%b want an=%b seg=%h dp=%b pm=%b",
                     j, an_a, seg_a, dp_a, pmled_a, e.an, e.seg, e.dp, e.pm);
         end
      end
   endtask

   task automatic test_update;
      rec_t e;
      push_frame(8, 2, 8'h12, 8'h00, 8'h00, 1'b0);
      push_frame(8, 2, 8'h09, 8'h05, 8'h30, 1'b1);
      for (int j = 0; j < 96; j++) begin
         @(negedge clk);
         e = q.pop_front();
         checks++;
         if ({an_a, seg_a, dp_a, pmled_a} !== e) begin
            errors++;
            $display("FAIL update cyc %0d got an=%b seg=%h dp=%b pm=%b want an=%b seg=%h dp=%b pm=%b",
                     j, an_a, seg_a, dp_a, pmled_a, e.an, e.seg, e.dp, e.pm);
         end
         if (j == 20) begin hh = 8'h09; mm = 8'h05; ss = 8'h30; pm = 1'b1; end
      end
   endtask

   task automatic test_colon;
      rec_t e;
      push_frame(8, 2, 8'h09, 8'h05, 8'h30, 1'b1);
      push_frame(8, 2, 8'h09, 8'h05, 8'h31, 1'b1);
      push_frame(8, 2, 8'h09, 8'h05, 8'h32, 1'b1);
      for (int j = 0; j < 144; j++) begin
         @(negedge clk);
         e = q.pop_front();
         checks++;
         if ({an_a, seg_a, dp_a, pmled_a} !== e) begin
            errors++;
            $display("FAIL colon cyc %0d got an=%b seg=%h dp=%b pm=%b want an=%b seg=%h dp=%b pm=%b",
                     j, an_a, seg_a, dp_a, pmled_a, e.an, e.seg, e.dp, e.pm);
         end
         if (j == 10) ss = 8'h31;
         if (j == 58) ss = 8'h32;
      end
   endtask

   task automatic test_bcd_err;
      rec_t e;
      push_frame(8, 2, 8'h09, 8'h05, 8'h32, 1'b1);
      push_frame(8, 2, 8'h09, 8'h5A, 8'h32, 1'b1);
      push_frame(8, 2, 8'h09, 8'h59, 8'h32, 1'b1);
      for (int j = 0; j < 144; j++) begin
         @(negedge clk);
         e = q.pop_front();
         checks++;
         if ({an_a, seg_a, dp_a, pmled_a} !== e) begin
            errors++;
            $display("FAIL bcd_frame cyc %0d got an=%b seg=%h dp=%b pm=%b want an=%b seg=%h dp=%b pm=%b",
                     j, an_a, seg_a, dp_a, pmled_a, e.an, e.seg, e.dp, e.pm);
         end
         if (j == 10) mm = 8'h5A;
         if (j == 58) mm = 8'h59;
         if (j == 46) begin
            checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL bcd_err_before_load got %b want 0", err_a); end
         end
         if (j == 47 || j == 143) begin
            checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL bcd_err_set cyc %0d got %b want 1", j, err_a); end
         end
      end
   endtask

   task automatic test_reset_mid;
      rec_t e;
      push_frame(8, 2, 8'h09, 8'h59, 8'h32, 1'b1);
      for (int j = 0; j < 29; j++) begin
         @(negedge clk);
         e = q.pop_front();
         checks++;
         if ({an_a, seg_a, dp_a, pmled_a} !== e) begin
            errors++;
            $display("FAIL pre_reset cyc %0d got an=%b seg=%h dp=%b pm=%b want an=%b seg=%h dp=%b pm=%b",
                     j, an_a, seg_a, dp_a, pmled_a, e.an, e.seg, e.dp, e.pm);
         end
      end
      q.delete();
      reset = 1'b1;
      #1;
      checks++; if (an_a !== 6'b111111) begin errors++; $display("FAIL midreset_an got %b want 111111", an_a); end
      checks++; if (seg_a !== 7'h7F) begin errors++; $display("FAIL midreset_seg got %h want 7f", seg_a); end
      checks++; if (pmled_a !== 1'b0) begin errors++; $display("FAIL midreset_pm_led got %b want 0", pmled_a); end
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL midreset_bcd_err got %b want 0", err_a); end
      @(negedge clk);
      reset = 1'b0;
      push_frame(8, 2, 8'h12, 8'h00, 8'h00, 1'b0);
      for (int j = 0; j < 48; j++) begin
         @(negedge clk);
         e = q.pop_front();
         checks++;
         if ({an_a, seg_a, dp_a, pmled_a} !== e) begin
            errors++;
            $display("FAIL post_reset cyc %0d got an=%b seg=%h dp=%b pm=%b want an=%b seg=%h dp=%b pm=%b",
                     j, an_a, seg_a, dp_a, pmled_a, e.an, e.seg, e.dp, e.pm);
         end
      end
      checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL post_reset_bcd_err got %b want 0", err_a); end
   endtask

   task automatic test_no_blank;
      rec_t e;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      push_frame(2, 0, 8'h12, 8'h00, 8'h00, 1'b0);
      push_frame(2, 0, 8'h09, 8'h59, 8'h32, 1'b1);
      push_frame(2, 0, 8'h11, 8'h22, 8'h33, 1'b0);
      for (int j = 0; j < 36; j++) begin
         @(negedge clk);
         e = q.pop_front();
         checks++;
         if ({an_b, seg_b, dp_b, pmled_b} !== e) begin
            errors++;
            $display("FAIL no_blank cyc %0d got an=%b seg=%h dp=%b pm=%b want an=%b seg=%h dp=%b pm=%b",
                     j, an_b, seg_b, dp_b, pmled_b, e.an, e.seg, e.dp, e.pm);
         end
         if (j == 15) begin hh = 8'h11; mm = 8'h22; ss = 8'h33; pm = 1'b0; end
         if (j == 29) hh = 8'h00;
         if (j == 34) begin
            checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL hh_zero_before_load got %b want 0", err_b); end
         end
         if (j == 35) begin
            checks++; if (err_b !== 1'b1) begin errors++; $display("FAIL hh_zero_err got %b want 1", err_b); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_update();
      test_colon();
      test_bcd_err();
      test_reset_mid();
      test_no_blank();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
